vend_dispense_sequencer: RTL and testbench
==========================================

# vend_dispense_sequencer

Sequences the physical delivery stage of the vending machine once a product and its change have been settled upstream. It accepts one vend request at a time over a valid/ready handshake, then works through three steps: drive the product motor, wait for the cup sensor, and pay out change as 25 Krs coin pulses. It sits between the selection/payment FSM and the dispenser/coin-hopper actuators, and it is the only block that drives those actuators.

## Interface
- DISP_CYCLES, 8, motor on-time in cycles (≥1)
- COIN_PULSE, 2, coin_out high cycles per coin (≥1)
- COIN_GAP, 2, coin_out low cycles after each coin (≥1)
- TIMEOUT, 64, cup-sensor wait limit in cycles (used only with VEND_TIMEOUT_EN)
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_product  in  2  01 tea, 10 coffee, 11 hot chocolate, 00 invalid
- req_change  in  8  change owed in Krs, unsigned
- sensor_cup  in  1  product-delivered sensor, synchronous to clk
- motor  out  3  one-hot: bit0 tea, bit1 coffee, bit2 hot chocolate
- coin_out  out  1  one pulse per 25 Krs coin
- change_left  out  8  change still to pay
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- error  out  1  sticky; cleared on next accepted request

## Operation
- States: IDLE, DISPENSE, WAIT_CUP, COIN_HI, COIN_LO, DONE.
- Accept: on a clk edge where req_valid && req_ready.
  - Latch the product and req_change into change_left.
  - Clear error.
  - Product 00 → set error, go to DONE with no motor or coin activity.
  - Otherwise → go to DISPENSE.
- DISPENSE: motor bit for the latched product high for exactly DISP_CYCLES cycles, then go to WAIT_CUP.
- WAIT_CUP:
  - motor = 0.
  - sensor_cup is sampled only in this state; pulses in any other state are ignored.
  - On sensor_cup = 1: go to COIN_HI if change_left ≥ 25, otherwise go to DONE.
- COIN_HI: coin_out = 1 for COIN_PULSE cycles. On the last cycle, change_left -= 25. Then go to COIN_LO.
- COIN_LO: coin_out = 0 for COIN_GAP cycles. Then go to COIN_HI if change_left ≥ 25, otherwise go to DONE.
- Change arithmetic: the number of coins is floor(req_change / 25). A remainder below 25 is not paid and stays visible on change_left. For example, 30 → 1 coin and change_left = 5.
- DONE: done = 1 for one cycle, then go to IDLE.
- req_valid outside IDLE is ignored. The upstream block holds the request until it sees req_ready.

## Timing
- Reset values (forced immediately and asynchronously while reset = 0, from any state):
  - state = IDLE
  - motor = 000, coin_out = 0, change_left = 0
  - busy = 0, done = 0, error = 0
  - req_ready = 1, because it is decoded from the IDLE state
- Reset in mid-operation aborts the vend at once: motor and coin_out drop to 0, and no done pulse is produced.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Latency for a request accepted at edge T:
  - motor high in cycles T+1 … T+DISP_CYCLES.
  - WAIT_CUP entered at T+DISP_CYCLES+1.
  - sensor_cup seen at edge E → first coin_out high at E+1, or done at E+1 if no coins are owed.
  - Each coin takes COIN_PULSE+COIN_GAP cycles.
  - done is high in the cycle after the last COIN_LO cycle.
- Back-to-back requests: req_ready returns in the cycle after done, so the earliest next accept is the edge at the end of that cycle.

## Configuration
- VEND_TIMEOUT_EN defined:
  - A counter runs in WAIT_CUP.
  - If sensor_cup has not been seen after TIMEOUT cycles, set error = 1 and go to DONE.
  - No coins are paid on timeout; change_left keeps the owed amount.
- VEND_TIMEOUT_EN undefined:
  - WAIT_CUP waits indefinitely and the counter logic is absent.
  - error is set only for product 00.

## Test plan
- Tea, change 0, accept at cycle 0, sensor_cup at cycle 10 → motor = 001 in cycles 1–8; done at cycle 11; coin_out never high.
- Hot chocolate, change 75 → motor = 100 for 8 cycles; then 3 coin_out pulses, each 2 high / 2 low; change_left goes 75 → 50 → 25 → 0; then a single done pulse.
- Coffee, change 30 → exactly 1 coin; change_left = 5 at done; error = 0.
- Product 00, change 50 → error = 1; done in the cycle after accept; motor and coin_out stay 0; error clears on the next valid accept.
- reset driven low during the second COIN_HI of a 75 Krs payout → coin_out, busy and motor drop to 0 immediately; after release, state is IDLE with req_ready = 1.
- VEND_TIMEOUT_EN defined and no sensor_cup → error = 1 and done at cycle accept+8+64+1. Without the macro → busy stays 1 for ≥200 cycles.

Source files
------------

// File: rtl/vend_dispense_sequencer.sv
// Dispense sequencer: motor run, cup-sensor wait, then 25 Krs coin payout.
// Optional VEND_TIMEOUT_EN bounds the cup-sensor wait at TIMEOUT cycles and flags error.
module vend_dispense_sequencer #(
    parameter int DISP_CYCLES = 8,
    parameter int COIN_PULSE  = 2,
    parameter int COIN_GAP    = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_product,
    input  logic [7:0] req_change,
    input  logic       sensor_cup,
    output logic [2:0] motor,
    output logic       coin_out,
    output logic [7:0] change_left,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int MAX_A   = (DISP_CYCLES > COIN_PULSE) ? DISP_CYCLES : COIN_PULSE;
    localparam int MAX_B   = (COIN_GAP > TIMEOUT) ? COIN_GAP : TIMEOUT;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DISP_LAST  = CNT_W'(DISP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(COIN_PULSE - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(COIN_GAP - 1);
    localparam logic [7:0]       COIN_VAL   = 8'd25;

    typedef enum logic [2:0] {
        S_IDLE, S_DISPENSE, S_WAIT_CUP, S_COIN_HI, S_COIN_LO, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       product_q, product_d;
    logic [7:0]       change_q, change_d;
    logic             error_q, error_d;

    function automatic logic [7:0] pay_coin(input logic [7:0] owed);
        return owed - COIN_VAL;
    endfunction

    function automatic logic [2:0] motor_bit(input logic [1:0] product);
        case (product)
            2'b01:   return 3'b001;
            2'b10:   return 3'b010;
            2'b11:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            product_q <= 2'b00;
            change_q  <= 8'd0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            change_q  <= change_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        product_d = product_q;
        change_d  = change_q;
        error_d   = error_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    product_d = req_product;
                    change_d  = req_change;
                    error_d   = (req_product == 2'b00);
                    state_d   = (req_product == 2'b00) ? S_DONE : S_DISPENSE;
                end
            end
            S_DISPENSE: begin
                if (cnt_q == DISP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_CUP;
                end
            end
            S_WAIT_CUP: begin
                if (sensor_cup) begin
                    cnt_d   = '0;
                    state_d = (change_q >= COIN_VAL) ? S_COIN_HI : S_DONE;
                end
`ifdef VEND_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Cup never arrived: abandon the vend, keep the owed change visible
                    cnt_d   = '0;
                    error_d = 1'b1;
                    state_d = S_DONE;
                end
`else
                else begin
                    cnt_d = '0;
                end
`endif
            end
            S_COIN_HI: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d    = '0;
                    change_d = pay_coin(change_q);
                    state_d  = S_COIN_LO;
                end
            end
            S_COIN_LO: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = (change_q >= COIN_VAL) ? S_COIN_HI : S_DONE;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode only from registered state, never from inputs
    always_comb begin
        req_ready   = (state_q == S_IDLE);
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        coin_out    = (state_q == S_COIN_HI);
        motor       = (state_q == S_DISPENSE) ? motor_bit(product_q) : 3'b000;
        change_left = change_q;
        error       = error_q;
    end

endmodule

// File: tb/tb_vend_dispense_sequencer.sv
// Randomised and directed bench for vend_dispense_sequencer against a timeline model.
module tb_vend_dispense_sequencer;

    localparam int DC = 8;
    localparam int P  = 2;
    localparam int G  = 2;
    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_product;
    logic [7:0] req_change;
    logic       sensor_cup;
    logic [2:0] motor;
    logic       coin_out;
    logic [7:0] change_left;
    logic       busy;
    logic       done;
    logic       error;

    vend_dispense_sequencer #(
        .DISP_CYCLES(DC), .COIN_PULSE(P), .COIN_GAP(G), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_product(req_product), .req_change(req_change), .sensor_cup(sensor_cup),
        .motor(motor), .coin_out(coin_out), .change_left(change_left),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: one vend described by accept cycle, sensor cycle and done cycle
    int c;
    bit m_busy, m_err, m_tmo;
    int m_a, m_prod, m_chg, m_e, m_done, m_cl_idle;

    int obs_done_c, obs_done_cl, coin_rises, a0;
    bit obs_done_err, prev_coin;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, c);
        end
    endtask

    function automatic int model_cl(input int cc);
        int mm, paid, n;
        if (m_e < 0 || cc <= m_e) return m_chg;
        mm   = cc - m_e - 1;
        paid = (mm >= P) ? ((mm - P) / (P + G) + 1) : 0;
        n    = m_chg / 25;
        if (paid > n) paid = n;
        return m_chg - 25 * paid;
    endfunction

    task automatic step(input bit v, input logic [1:0] p, input logic [7:0] ch, input bit s);
        int er, eb, em, eco, ed, ecl, d;
        @(negedge clk);
        if (!m_busy) begin
            er = 1; eb = 0; em = 0; eco = 0; ed = 0; ecl = m_cl_idle;
        end else begin
            d   = c - m_a;
            er  = 0;
            eb  = 1;
            em  = (m_prod != 0 && d >= 1 && d <= DC) ? (1 << (m_prod - 1)) : 0;
            eco = 0;
            if (m_e >= 0 && c > m_e && c < m_done)
                eco = (((c - m_e - 1) % (P + G)) < P) ? 1 : 0;
            ed  = (c == m_done) ? 1 : 0;
            ecl = model_cl(c);
        end
        chk("req_ready",   32'(req_ready),   er);
        chk("busy",        32'(busy),        eb);
        chk("motor",       32'(motor),       em);
        chk("coin_out",    32'(coin_out),    eco);
        chk("done",        32'(done),        ed);
        chk("change_left", 32'(change_left), ecl);
        chk("error",       32'(error),       32'(m_err));

        if (done === 1'b1) begin
            obs_done_c   = c;
            obs_done_cl  = int'(change_left);
            obs_done_err = error;
        end
        if (coin_out === 1'b1 && !prev_coin) coin_rises++;
        prev_coin = (coin_out === 1'b1);

        req_valid   = v;
        req_product = p;
        req_change  = ch;
        sensor_cup  = s;

        if (!m_busy) begin
            if (v) begin
                m_busy = 1; m_a = c; m_prod = int'(p); m_chg = int'(ch);
                m_e = -1; m_tmo = 0; m_err = (p == 2'b00);
                m_done = (p == 2'b00) ? c + 1 : (1 << 30);
            end
        end else if (c == m_done) begin
            m_busy    = 0;
            m_cl_idle = ecl;
        end else if (m_prod != 0 && m_e < 0 && !m_tmo && c >= m_a + DC + 1) begin
            if (s) begin
                m_e    = c;
                m_done = c + 1 + (m_chg / 25) * (P + G);
            end
`ifdef VEND_TIMEOUT_EN
            else if (c == m_a + DC + TO) begin
                m_tmo  = 1;
                m_err  = 1;
                m_done = c + 1;
            end
`endif
        end
        c++;
    endtask

    task automatic run_vend(input logic [1:0] p, input logic [7:0] ch, input int s_at, input int max);
        a0 = c;
        coin_rises = 0;
        obs_done_c = -1;
        step(1'b1, p, ch, 1'b0);
        for (int i = 0; i < max && m_busy; i++)
            step(1'b0, p, ch, (c == a0 + s_at));
        chk("vend_finished", 32'(m_busy), 0);
        step(1'b0, 2'b00, 8'd0, 1'b0);
    endtask

    task automatic pin(input string tag, input int rel_done, input int coins, input int cl, input int err);
        chk({tag, "_done_cycle"}, obs_done_c - a0, rel_done);
        chk({tag, "_coins"},      coin_rises,      coins);
        chk({tag, "_change"},     obs_done_cl,     cl);
        chk({tag, "_error"},      32'(obs_done_err), err);
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_product = 2'b00; req_change = 8'd0; sensor_cup = 1'b0;
        c = 0; m_busy = 0; m_err = 0; m_tmo = 0; m_cl_idle = 0; m_e = -1;
        m_a = 0; m_prod = 0; m_chg = 0; m_done = 0; prev_coin = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_motor", 32'(motor), 0);
        chk("rst_coin",  32'(coin_out), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_cl",    32'(change_left), 0);
        chk("rst_err",   32'(error), 0);
        reset = 1'b1;
        step(1'b0, 2'b00, 8'd0, 1'b0);
        step(1'b0, 2'b00, 8'd0, 1'b0);

        run_vend(2'b01, 8'd0, 10, 60);   pin("tea0", 11, 0, 0, 0);
        run_vend(2'b11, 8'd75, 10, 60);  pin("choc75", 23, 3, 0, 0);
        run_vend(2'b10, 8'd30, 12, 60);  pin("coffee30", 17, 1, 5, 0);
        run_vend(2'b00, 8'd50, 5, 60);   pin("invalid", 1, 0, 50, 1);
        run_vend(2'b01, 8'd25, 9, 60);   pin("tea25", 14, 1, 0, 0);
        run_vend(2'b10, 8'd40, 205, 260);
`ifdef VEND_TIMEOUT_EN
        pin("nocup", 73, 0, 40, 1);
`else
        pin("nocup", 210, 1, 15, 0);
`endif

        // Abort during the second coin-high cycle of a 75 Krs payout
        a0 = c;
        step(1'b1, 2'b11, 8'd75, 1'b0);
        for (int i = 0; i < 15; i++)
            step(1'b0, 2'b11, 8'd75, (c == a0 + 10));
        chk("abort_in_coin", 32'(coin_out), 1);
        reset = 1'b0;
        #1;
        chk("abort_coin",  32'(coin_out), 0);
        chk("abort_busy",  32'(busy), 0);
        chk("abort_motor", 32'(motor), 0);
        chk("abort_ready", 32'(req_ready), 1);
        chk("abort_done",  32'(done), 0);
        m_busy = 0; m_err = 0; m_cl_idle = 0; prev_coin = 0;
        step(1'b0, 2'b00, 8'd0, 1'b0);
        step(1'b0, 2'b00, 8'd0, 1'b0);
        reset = 1'b1;
        step(1'b0, 2'b00, 8'd0, 1'b0);
        run_vend(2'b01, 8'd0, 9, 60);    pin("after_abort", 10, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            logic [7:0] ch;
            ch = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 130));
            step(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), ch,
                 ($urandom_range(0, 4) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
